// File: rtl/multi_req_driver.sv
// rtl/multi_req_driver.sv - start/done protocol initiator with request/response handshakes
module multi_req_driver #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic             start,
    output logic [WIDTH-1:0] in,
    input  logic             done,
    input  logic [WIDTH-1:0] out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_timeout,
    output logic [3:0]       resp_latency,
    output logic             err_spurious
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    logic [1:0]       state;
    logic [WIDTH-1:0] op_buf;
    logic [3:0]       wait_cnt;

    // Handshake outputs come straight from the state register, so no input reaches them combinationally.
    assign req_ready  = (state == S_IDLE);
    assign start      = (state == S_START);
    assign resp_valid = (state == S_RESP);
    assign in         = start ? op_buf : '0;

    // Transaction sequencer: accept, pulse start, wait for done or timeout, hold response until taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            op_buf       <= '0;
            wait_cnt     <= 4'd0;
            resp_data    <= '0;
            resp_timeout <= 1'b0;
            resp_latency <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_buf <= req_data;
                        state  <= S_START;
                    end
                end
                S_START: begin
                    // done here still reflects the unit's previous operation
                    wait_cnt <= 4'd1;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (done) begin
                        resp_data    <= out;
                        resp_latency <= wait_cnt;
                        resp_timeout <= 1'b0;
                        state        <= S_RESP;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        resp_data    <= '0;
                        resp_latency <= TIMEOUT_CNT;
                        resp_timeout <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sticky flag for a done strobe arriving while no operation is outstanding.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_spurious <= 1'b0;
        end else if (done && (state != S_WAIT)) begin
            err_spurious <= 1'b1;
        end
    end

endmodule
